map_latch_gen: RTL and testbench

Parametrised discrete-latch mapper core for simple NES boards: one write-only latch that holds a PRG bank and a CHR bank. It generalises the fixed two-bit CHR latch in the `$6000` window to these configurable features:
- register window;
- field widths and positions;
- CHR bit-swap;
- optional PRG banking;
- ROM bus-conflict emulation;
- save-state access.

It sits between the cartridge bus interface and the PRG/CHR memory address outputs. It runs from the system clock and samples `m2` rather than using `m2` as its clock.

---
 rtl/map_latch_gen.sv | 186 ++++++++++++++++++
 tb/tb_map_latch_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/map_latch_gen.sv
// map_latch_gen: parametrised discrete-latch mapper core. A single write-only
// latch holds a PRG bank and a CHR bank. CPU writes are detected by sampling a
// synchronised m2 on the system clock and committed after m2 falls.
module map_latch_gen #(
  parameter logic [15:0] REG_BASE     = 16'h6000,
  parameter logic [15:0] REG_MASK     = 16'hE000,
  parameter bit          PRG_EN       = 1'b0,
  parameter int          PRG_BITS     = 2,
  parameter int          PRG_LSB      = 4,
  parameter int          CHR_BITS     = 2,
  parameter int          CHR_LSB      = 0,
  parameter bit          CHR_SWAP     = 1'b1,
  parameter bit          BUS_CONFLICT = 1'b0,
  parameter logic [7:0]  MAP_IDX      = 8'd87
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   m2,
  input  logic                   cpu_rw,
  input  logic [15:0]            cpu_addr,
  input  logic [7:0]             cpu_dat,
  input  logic [7:0]             rom_dat,
  input  logic [13:0]            ppu_addr,
  input  logic                   cfg_mir_v,
  input  logic                   ss_act,
  input  logic                   ss_we,
  input  logic [7:0]             ss_addr,
  output logic [15+PRG_BITS-1:0] prg_addr,
  output logic [13+CHR_BITS-1:0] chr_addr,
  output logic                   ciram_a10,
  output logic                   ciram_ce,
  output logic                   rom_ce,
  output logic [7:0]             ss_rdat,
  output logic                   wr_stb
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIGH   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Extract a 4-bit window of a byte starting at lsb; bits beyond bit 7 read 0.
  function automatic logic [3:0] field8(input logic [7:0] v, input int lsb);
    logic [15:0] ext;
    ext = {8'h00, v} >> lsb;
    return ext[3:0];
  endfunction

  logic                m2_meta_q, m2_s_q, m2_prev_q;
  logic                m2_fall;
  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [15:0]         addr_q, addr_d;
  logic [7:0]          dat_q, dat_d;
  logic [7:0]          rom_q, rom_d;
  logic                rw_q, rw_d;
  logic [CHR_BITS-1:0] chr_q, chr_d;
  logic [PRG_BITS-1:0] prg_q, prg_d;
  logic                wr_stb_q, wr_stb_d;

  // Work variables for the commit datapath.
  logic [7:0] eff_dat;
  logic [3:0] chr_fld, prg_fld, raw_fld;

  // Two-flop synchroniser for m2 plus a delayed copy for fall detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_meta_q <= 1'b0;
      m2_s_q    <= 1'b0;
      m2_prev_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours, which is what makes the
      // two-flop chain a chain rather than a single wire.
      m2_meta_q <= m2;
      m2_s_q    <= m2_meta_q;
      m2_prev_q <= m2_s_q;
    end
  end

  assign m2_fall = m2_prev_q & ~m2_s_q;

  // State, capture and latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      dat_q    <= '0;
      rom_q    <= '0;
      rw_q     <= 1'b1;
      chr_q    <= '0;
      prg_q    <= '0;
      wr_stb_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      dat_q    <= dat_d;
      rom_q    <= rom_d;
      rw_q     <= rw_d;
      chr_q    <= chr_d;
      prg_q    <= prg_d;
      wr_stb_q <= wr_stb_d;
    end
  end

  // Write FSM: capture the bus while m2 is high, commit once after it falls.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    dat_d    = dat_q;
    rom_d    = rom_q;
    rw_d     = rw_q;
    chr_d    = chr_q;
    prg_d    = prg_q;
    wr_stb_d = 1'b0;
    eff_dat  = dat_q;
    chr_fld  = '0;
    prg_fld  = '0;
    raw_fld  = dat_q[3:0];

    unique case (state_q)
      ST_IDLE: begin
        if (m2_s_q) begin
          state_d = ST_HIGH;
          cnt_d   = 2'd1;
          addr_d  = cpu_addr;
          dat_d   = cpu_dat;
          rom_d   = rom_dat;
          rw_d    = cpu_rw;
        end
      end
      ST_HIGH: begin
        if (m2_fall) begin
          // A single high sample is treated as a glitch and dropped.
          state_d = (cnt_q >= 2'd2) ? ST_COMMIT : ST_IDLE;
        end else begin
          cnt_d  = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
          addr_d = cpu_addr;
          dat_d  = cpu_dat;
          rom_d  = rom_dat;
          rw_d   = cpu_rw;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (ss_act) begin
          // Save-state restore: raw loads, CPU writes ignored, no strobe.
          if (ss_we && ss_addr == 8'd0) chr_d = raw_fld[CHR_BITS-1:0];
          if (ss_we && ss_addr == 8'd1 && PRG_EN) prg_d = raw_fld[PRG_BITS-1:0];
        end else if (!rw_q && ((addr_q & REG_MASK) == REG_BASE)) begin
          if (BUS_CONFLICT && addr_q[15]) eff_dat = dat_q & rom_q;
          chr_fld = field8(eff_dat, CHR_LSB);
          if (CHR_SWAP && CHR_BITS >= 2) chr_fld[1:0] = {chr_fld[0], chr_fld[1]};
          prg_fld = field8(eff_dat, PRG_LSB);
          chr_d   = chr_fld[CHR_BITS-1:0];
          if (PRG_EN) prg_d = prg_fld[PRG_BITS-1:0];
          wr_stb_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address generation and save-state readback.
  always_comb begin
    prg_addr  = {prg_q, cpu_addr[14:0]};
    chr_addr  = {chr_q, ppu_addr[12:0]};
    ciram_ce  = ~ppu_addr[13];
    ciram_a10 = cfg_mir_v ? ppu_addr[10] : ppu_addr[11];
    rom_ce    = cpu_addr[15];
    wr_stb    = wr_stb_q;
    case (ss_addr)
      8'd0:    ss_rdat = {{(8-CHR_BITS){1'b0}}, chr_q};
      8'd1:    ss_rdat = {{(8-PRG_BITS){1'b0}}, prg_q};
      8'd127:  ss_rdat = MAP_IDX;
      default: ss_rdat = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_map_latch_gen.sv
// Testbench for map_latch_gen: two instances (default board and a PRG-banked
// bus-conflict board) share one CPU/PPU bus; a scoreboard checks each latch
// commit against a behavioural model of the board.
`timescale 1ns/1ps
module tb_map_latch_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m2 = 1'b0;
  logic        cpu_rw = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dat = '0;
  logic [7:0]  rom_dat = 8'hFF;
  logic [13:0] ppu_addr = '0;
  logic        cfg_mir_v = 1'b0;
  logic        ss_act = 1'b0;
  logic        ss_we = 1'b0;
  logic [7:0]  ss_addr = '0;

  logic [16:0] prg_addr_a, prg_addr_b;
  logic [14:0] chr_addr_a, chr_addr_b;
  logic        ciram_a10_a, ciram_a10_b, ciram_ce_a, ciram_ce_b;
  logic        rom_ce_a, rom_ce_b, wr_stb_a, wr_stb_b;
  logic [7:0]  ss_rdat_a, ss_rdat_b;

  map_latch_gen dut_a (
    .clk(clk), .rst_n(rst_n), .m2(m2), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_dat(cpu_dat), .rom_dat(rom_dat), .ppu_addr(ppu_addr), .cfg_mir_v(cfg_mir_v),
    .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .prg_addr(prg_addr_a),
    .chr_addr(chr_addr_a), .ciram_a10(ciram_a10_a), .ciram_ce(ciram_ce_a),
    .rom_ce(rom_ce_a), .ss_rdat(ss_rdat_a), .wr_stb(wr_stb_a)
  );

  map_latch_gen #(
    .REG_BASE(16'h8000), .REG_MASK(16'h8000), .PRG_EN(1'b1), .BUS_CONFLICT(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .m2(m2), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_dat(cpu_dat), .rom_dat(rom_dat), .ppu_addr(ppu_addr), .cfg_mir_v(cfg_mir_v),
    .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .prg_addr(prg_addr_b),
    .chr_addr(chr_addr_b), .ciram_a10(ciram_a10_b), .ciram_ce(ciram_ce_b),
    .rom_ce(rom_ce_b), .ss_rdat(ss_rdat_b), .wr_stb(wr_stb_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Board model state and scoreboard queues.
  logic [1:0] m_chr_a = '0, m_chr_b = '0, m_prg_b = '0;
  int qa[$];
  int qb[$];
  int exp_stb_a = 0, exp_stb_b = 0, seen_stb_a = 0, seen_stb_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Board behaviour written from the rules: board A decodes $6000-$7FFF,
  // board B decodes $8000-$FFFF with bus conflicts; both swap CHR bits.
  task automatic model_apply(input logic [15:0] a, input logic [7:0] d, input logic [7:0] r,
                             input logic rw, input int high, input logic sa, input logic sw,
                             input logic [7:0] sidx);
    logic [7:0] v;
    if (high < 2) return;
    if (sa) begin
      if (sw && sidx == 8'd0) begin
        m_chr_a = d[1:0];
        m_chr_b = d[1:0];
      end
      if (sw && sidx == 8'd1) m_prg_b = d[1:0];
      return;
    end
    if (rw) return;
    if (a >= 16'h6000 && a <= 16'h7FFF) begin
      m_chr_a = {d[0], d[1]};
      qa.push_back(int'(m_chr_a));
      exp_stb_a++;
    end
    if (a >= 16'h8000) begin
      v = d & r;
      m_chr_b = {v[0], v[1]};
      m_prg_b = v[5:4];
      qb.push_back(int'({m_prg_b, m_chr_b}));
      exp_stb_b++;
    end
  endtask

  // Monitor: every strobe pops the next expected bank value.
  always @(negedge clk) begin
    int e;
    if (wr_stb_a) begin
      seen_stb_a++;
      if (qa.size() == 0) check("stb_a_unexpected", 1, 0);
      else begin
        e = qa.pop_front();
        check("sb_chr_a", 32'(chr_addr_a[14:13]), e);
      end
    end
    if (wr_stb_b) begin
      seen_stb_b++;
      if (qb.size() == 0) check("stb_b_unexpected", 1, 0);
      else begin
        e = qb.pop_front();
        check("sb_bank_b", 32'({prg_addr_b[16:15], chr_addr_b[14:13]}), e);
      end
    end
  end

  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic [7:0] r,
                           input logic rw, input int high, input logic sa = 1'b0,
                           input logic sw = 1'b0, input logic [7:0] sidx = 8'd0);
    @(negedge clk);
    cpu_addr = a; cpu_dat = d; rom_dat = r; cpu_rw = rw;
    ss_act = sa; ss_we = sw; ss_addr = sidx;
    m2 = 1'b1;
    repeat (high) @(negedge clk);
    m2 = 1'b0;
    model_apply(a, d, r, rw, high, sa, sw, sidx);
    repeat (6) @(negedge clk);
    ss_act = 1'b0; ss_we = 1'b0; cpu_rw = 1'b1;
  endtask

  // Drive random PPU/CPU addresses while idle and compare address outputs.
  task automatic check_outputs(input string tag);
    ppu_addr  = 14'($urandom);
    cpu_addr  = 16'($urandom);
    cfg_mir_v = 1'($urandom);
    #1;
    check({tag, "_chr_a"}, 32'(chr_addr_a), 32'({m_chr_a, ppu_addr[12:0]}));
    check({tag, "_prg_a"}, 32'(prg_addr_a), 32'({2'b00, cpu_addr[14:0]}));
    check({tag, "_chr_b"}, 32'(chr_addr_b), 32'({m_chr_b, ppu_addr[12:0]}));
    check({tag, "_prg_b"}, 32'(prg_addr_b), 32'({m_prg_b, cpu_addr[14:0]}));
    check({tag, "_ciram"}, 32'({ciram_ce_a, ciram_a10_a, rom_ce_a}),
          32'({!ppu_addr[13], cfg_mir_v ? ppu_addr[10] : ppu_addr[11], cpu_addr[15]}));
  endtask

  task automatic check_ss(input string tag);
    logic [7:0] other;
    ss_addr = 8'd0;   #1;
    check({tag, "_ss0_a"}, 32'(ss_rdat_a), 32'({6'b0, m_chr_a}));
    ss_addr = 8'd1;   #1;
    check({tag, "_ss1_a"}, 32'(ss_rdat_a), 32'h00);
    check({tag, "_ss1_b"}, 32'(ss_rdat_b), 32'({6'b0, m_prg_b}));
    ss_addr = 8'd127; #1;
    check({tag, "_ss127_a"}, 32'(ss_rdat_a), 32'd87);
    other = 8'($urandom_range(2, 126));
    ss_addr = other;  #1;
    check({tag, "_ssff_b"}, 32'(ss_rdat_b), 32'hFF);
    ss_addr = 8'd0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra;
    int cls;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("reset");
    check_ss("reset");

    // Latency from raw m2 fall: bank must change exactly on the 4th edge.
    @(negedge clk);
    cpu_addr = 16'h6000; cpu_dat = 8'h01; rom_dat = 8'hFF; cpu_rw = 1'b0;
    m2 = 1'b1;
    repeat (2) @(negedge clk);
    m2 = 1'b0;
    model_apply(16'h6000, 8'h01, 8'hFF, 1'b0, 2, 1'b0, 1'b0, 8'd0);
    repeat (3) @(negedge clk);
    check("lat_edge3_chr", 32'(chr_addr_a[14:13]), 32'd0);
    @(negedge clk);
    check("lat_edge4_chr", 32'(chr_addr_a[14:13]), 32'd2);
    repeat (4) @(negedge clk);
    cpu_rw = 1'b1;
    check_outputs("write01");

    // Window edges: $7FFF hits board A, $8000 hits board B only.
    bus_cycle(16'h7FFF, 8'h03, 8'hFF, 1'b0, 2);
    check_outputs("w7fff");
    bus_cycle(16'h8000, 8'h03, 8'hFF, 1'b0, 2);
    check_outputs("w8000");

    // Bus conflict on board B: 0x33 & 0x21 = 0x21 -> prg 2, chr 01 swapped to 2.
    bus_cycle(16'h8000, 8'h33, 8'h21, 1'b0, 3);
    check("bc_prg_b", 32'(prg_addr_b[16:15]), 32'd2);
    check("bc_chr_b", 32'(chr_addr_b[14:13]), 32'd2);

    // One-sample m2 glitch must not commit.
    bus_cycle(16'h6000, 8'h01, 8'hFF, 1'b0, 1);
    check_outputs("glitch");

    // Save-state loads: raw, no swap, no strobe, CPU write ignored.
    bus_cycle(16'h6000, 8'h02, 8'hFF, 1'b0, 2, 1'b1, 1'b1, 8'd0);
    check("ss_chr_a", 32'(chr_addr_a[14:13]), 32'd2);
    bus_cycle(16'h8000, 8'h03, 8'hFF, 1'b0, 2, 1'b1, 1'b1, 8'd1);
    check_outputs("ss");
    check_ss("ss");

    // Randomised writes across the address space, some glitches and reads.
    for (int i = 0; i < 40; i++) begin
      cls = $urandom_range(0, 3);
      case (cls)
        0:       ra = 16'h6000 | 16'($urandom_range(0, 16'h1FFF));
        1:       ra = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        2:       ra = 16'h4000 | 16'($urandom_range(0, 16'h1FFF));
        default: ra = 16'($urandom);
      endcase
      bus_cycle(ra, 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
                $urandom_range(1, 4));
      check_outputs("rand");
    end
    check_ss("rand");

    // Reset asserted during the high phase: pending write lost, banks cleared.
    bus_cycle(16'h6000, 8'h01, 8'hFF, 1'b0, 2);
    bus_cycle(16'hC000, 8'h30, 8'hFF, 1'b0, 2);
    @(negedge clk);
    cpu_addr = 16'h6000; cpu_dat = 8'h03; cpu_rw = 1'b0;
    m2 = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    m_chr_a = '0; m_chr_b = '0; m_prg_b = '0;
    @(negedge clk);
    m2 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    cpu_rw = 1'b1;
    check_outputs("rst_mid");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && (qa.size() + qb.size()) != 0; i++) @(negedge clk);
    check("drain_pending", 32'(qa.size() + qb.size()), 32'd0);
    check("stb_count_a", 32'(seen_stb_a), 32'(exp_stb_a));
    check("stb_count_b", 32'(seen_stb_b), 32'(exp_stb_b));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
